// File: rtl/gray_input_ctrl.sv
// Gray-code switch input controller.
// Synchronizes a 4-bit Gray code from switches, debounces it and converts each
// accepted change to binary. An accepted change produces a one-cycle valid pulse
// and increments an event counter. The LED outputs are active-low copies of binary_out.
module gray_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] gray_in,
    input  logic       hold,
    output logic [3:0] binary_out,
    output logic [3:0] leds,
    output logic       valid,
    output logic       busy,
    output logic [7:0] event_cnt
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        CONVERT,
        UPDATE
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       sync1_q;
    logic [3:0]       gray_s_q;
    logic [3:0]       gray_q, gray_d;
    logic [3:0]       gray_c_q, gray_c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bin_q, bin_d;
    logic [7:0]       event_q, event_d;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Two-flop synchronizer for the asynchronous switch inputs.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            gray_s_q <= '0;
        end else begin
            sync1_q  <= gray_in;
            gray_s_q <= sync1_q;
        end
    end

    // State and datapath registers; every register clears at once on reset.
    // NOTE: asynchronous reset acts immediately, so a sequence cut off mid-debounce leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gray_q   <= '0;
            gray_c_q <= '0;
            cnt_q    <= '0;
            bin_q    <= '0;
            event_q  <= '0;
        end else begin
            state_q  <= state_d;
            gray_q   <= gray_d;
            gray_c_q <= gray_c_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            event_q  <= event_d;
        end
    end

    // Next-state logic: start a debounce on a new code, qualify it, then commit it.
    always_comb begin
        // NOTE: defaulting every output first ensures that no path can infer a latch.
        state_d  = state_q;
        gray_d   = gray_q;
        gray_c_d = gray_c_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        event_d  = event_q;
        case (state_q)
            IDLE: begin
                if (!hold && (gray_s_q != gray_q)) begin
                    gray_c_d = gray_s_q;
                    cnt_d    = '0;
                    state_d  = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (gray_s_q != gray_c_q) begin
                    // Input moved again: track the new candidate and restart the count.
                    gray_c_d = gray_s_q;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = CONVERT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CONVERT: begin
                if (gray_c_q != gray_q) begin
                    gray_d  = gray_c_q;
                    bin_d   = gray2bin(gray_c_q);
                    event_d = event_q + 8'd1;
                    state_d = UPDATE;
                end else begin
                    // The bounce settled back on the accepted code, so nothing to report.
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign binary_out = bin_q;
    assign leds       = ~bin_q;
    assign event_cnt  = event_q;
    assign valid      = (state_q == UPDATE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gray_input_ctrl.sv
// Self-checking bench for gray_input_ctrl. A behavioural model predicts the
// outputs after every clock edge. The model tracks how many consecutive
// synchronized samples agree with the candidate code. Directed scenarios
// cover latency, bounce, glitch, hold, mid-debounce reset and counter wrap.
// These are followed by randomized traffic.
module tb_gray_input_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       hold;
    logic [3:0] binary_out;
    logic [3:0] leds;
    logic       valid;
    logic       busy;
    logic [7:0] event_cnt;

    gray_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .hold       (hold),
        .binary_out (binary_out),
        .leds       (leds),
        .valid      (valid),
        .busy       (busy),
        .event_cnt  (event_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_seen;
    bit busy_seen;

    // Reference model state
    logic [3:0] m_pipe1, m_pipe2;  // two-edge delay of gray_in
    logic [3:0] m_acc;             // last accepted Gray code
    logic [3:0] m_cand;            // code currently being qualified
    logic [3:0] m_bin;
    logic [7:0] m_events;
    bit         m_active;          // a sequence is in progress (busy)
    int         m_run;             // samples agreeing with m_cand; D+1 = qualified, D+2 = announcing

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, req, $time);
    endtask

    function automatic logic [3:0] to_binary(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic model_reset();
        m_pipe1  = '0;
        m_pipe2  = '0;
        m_acc    = '0;
        m_cand   = '0;
        m_bin    = '0;
        m_events = '0;
        m_active = 1'b0;
        m_run    = 0;
    endtask

    // Advance the model by one rising edge, using the inputs present before that edge.
    task automatic model_step(input logic [3:0] g, input logic h);
        logic [3:0] s;
        s = m_pipe2;
        if (!m_active) begin
            if (!h && s != m_acc) begin
                m_active = 1'b1;
                m_cand   = s;
                m_run    = 1;
            end
        end else if (m_run <= D) begin
            if (s != m_cand) begin
                m_cand = s;
                m_run  = 1;
            end else begin
                m_run++;
            end
        end else if (m_run == D + 1) begin
            if (m_cand != m_acc) begin
                m_acc    = m_cand;
                m_bin    = to_binary(m_cand);
                m_events = m_events + 8'd1;
                m_run    = D + 2;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_active = 1'b0;
        end
        m_pipe2 = m_pipe1;
        m_pipe1 = g;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] exp_leds;
        logic       exp_valid;
        exp_leds  = ~m_bin;
        exp_valid = m_active && (m_run == D + 2);
        check({tag, ".binary_out"}, 32'(binary_out), 32'(m_bin));
        check({tag, ".leds"},       32'(leds),       32'(exp_leds));
        check({tag, ".valid"},      32'(valid),      32'(exp_valid));
        check({tag, ".busy"},       32'(busy),       32'(m_active));
        check({tag, ".event_cnt"},  32'(event_cnt),  32'(m_events));
        if (valid === 1'b1) valid_seen++;
        if (busy === 1'b1) busy_seen = 1'b1;
    endtask

    task automatic step_cycle(input logic [3:0] g, input logic h);
        gray_in = g;
        hold    = h;
        @(posedge clk);
        model_step(g, h);
        #1;
        check_outputs("cyc");
    endtask

    // Assert reset between edges, check the immediate effect, then release before the next edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.binary_out", 32'(binary_out), 32'(4'h0));
        check("rst.leds",       32'(leds),       32'(4'hF));
        check("rst.valid",      32'(valid),      32'(1'b0));
        check("rst.busy",       32'(busy),       32'(1'b0));
        check("rst.event_cnt",  32'(event_cnt),  32'(8'h00));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] target;
        logic       h;
        bit         got;

        rst_n   = 1'b1;
        gray_in = 4'h0;
        hold    = 1'b0;
        model_reset();
        #1;
        pulse_reset();

        // Latency: 0110 applied before edge 0 is accepted at edge 7.
        for (int i = 0; i < 7; i++) step_cycle(4'b0110, 1'b0);
        check("lat.before", 32'(binary_out), 32'(4'b0000));
        step_cycle(4'b0110, 1'b0);
        check("lat.binary_out", 32'(binary_out), 32'(4'b0100));
        check("lat.leds",       32'(leds),       32'(4'b1011));
        check("lat.event_cnt",  32'(event_cnt),  32'(8'd1));
        check("lat.valid",      32'(valid),      32'(1'b1));
        step_cycle(4'b0110, 1'b0);
        check("lat.valid_after", 32'(valid), 32'(1'b0));

        // Bounce: six cycles toggling 0001/0000, then settling at 0001.
        pulse_reset();
        valid_seen = 0;
        for (int i = 0; i < 6; i++) step_cycle((i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step_cycle(4'b0001, 1'b0);
            if (k == 7) check("bounce.before", 32'(binary_out), 32'(4'b0000));
            if (k == 8) check("bounce.binary_out", 32'(binary_out), 32'(4'b0001));
        end
        check("bounce.pulses", 32'(valid_seen), 32'(1));

        // Glitch: two cycles of 0011, then back to 0000.
        pulse_reset();
        for (int i = 0; i < 3; i++) step_cycle(4'b0000, 1'b0);
        valid_seen = 0;
        busy_seen  = 1'b0;
        step_cycle(4'b0011, 1'b0);
        step_cycle(4'b0011, 1'b0);
        for (int i = 0; i < 15; i++) step_cycle(4'b0000, 1'b0);
        check("glitch.pulses",     32'(valid_seen), 32'(0));
        check("glitch.busy_rose",  32'(busy_seen),  32'(1'b1));
        check("glitch.busy_now",   32'(busy),       32'(1'b0));
        check("glitch.binary_out", 32'(binary_out), 32'(4'b0000));
        check("glitch.event_cnt",  32'(event_cnt),  32'(8'd0));

        // Hold: a new code is ignored while hold is high in IDLE.
        busy_seen = 1'b0;
        for (int i = 0; i < 10; i++) step_cycle(4'b1000, 1'b1);
        check("hold.busy_seen",  32'(busy_seen),  32'(1'b0));
        check("hold.binary_out", 32'(binary_out), 32'(4'b0000));
        valid_seen = 0;
        for (int i = 0; i < 12; i++) step_cycle(4'b1000, 1'b0);
        check("hold.pulses",     32'(valid_seen), 32'(1));
        check("hold.binary_out", 32'(binary_out), 32'(4'b1111));

        // Reset in the middle of a debounce sequence.
        pulse_reset();
        for (int i = 0; i < 4; i++) step_cycle(4'b1000, 1'b0);
        check("midrst.busy", 32'(busy), 32'(1'b1));
        valid_seen = 0;
        pulse_reset();
        check("midrst.pulses", 32'(valid_seen), 32'(0));
        for (int i = 0; i < 14; i++) step_cycle(4'b1000, 1'b0);
        check("midrst.event_cnt",  32'(event_cnt),  32'(8'd1));
        check("midrst.binary_out", 32'(binary_out), 32'(4'b1111));
        check("midrst.pulses2",    32'(valid_seen), 32'(1));

        // 256 accepted changes alternating 0001/0000: event_cnt wraps to 0.
        pulse_reset();
        for (int n = 0; n < 256; n++) begin
            target = (n % 2 == 0) ? 4'b0001 : 4'b0000;
            got    = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                step_cycle(target, 1'b0);
                if (valid === 1'b1) begin
                    got = 1'b1;
                    check("wrap.binary_out", 32'(binary_out), 32'(to_binary(target)));
                end
            end
            check("wrap.pulse_seen", 32'(got), 32'(1'b1));
        end
        step_cycle(4'b0000, 1'b0);
        check("wrap.event_cnt", 32'(event_cnt), 32'(8'd0));

        // Randomized traffic with hold and occasional resets.
        pulse_reset();
        cur = 4'h0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5, 0) == 0) cur = 4'($urandom_range(15, 0));
            h = ($urandom_range(4, 0) == 0);
            if ($urandom_range(299, 0) == 0) pulse_reset();
            step_cycle(cur, h);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
